// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
// Bundles the display driver's data-side inputs and its pin-side outputs.
//   value[4*NUM_DIGITS]  hex nibbles, digit 0 rightmost
//   dp / blank           per-digit decimal point / force-dark
//   load                 one-cycle capture strobe
//   lz_suppress          live leading-zero suppression enable
//   brightness           live PWM duty level
//   seg / dp_n / an      active-low segment, decimal point and anode drives
//   frame_tick           pulse in the first cycle of each new frame
//   upd_pending          pending buffer not yet applied
// The master modport is the producer of display values; the slave modport is the driver.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    load;
    logic                    lz_suppress;
    logic [BRIGHT_W-1:0]     brightness;
    logic [6:0]              seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;
    logic                    upd_pending;

    modport master (
        output value, dp, blank, load, lz_suppress, brightness,
        input  seg, dp_n, an, frame_tick, upd_pending
    );

    modport slave (
        input  value, dp, blank, load, lz_suppress, brightness,
        output seg, dp_n, an, frame_tick, upd_pending
    );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display
// Multiplexed common-anode seven-segment driver. Scans NUM_DIGITS digits from a
// double-buffered hex word with per-digit dp/blanking, leading-zero suppression,
// a dead time at the start of every digit slot and PWM brightness.
// Ports:
//   mclk   system clock
//   reset  synchronous active-high reset
//   bus    seg_scan_display_if.slave (inputs value/dp/blank/load/lz_suppress/
//          brightness; outputs seg/dp_n/an/frame_tick/upd_pending)
// All outputs are registered and reflect the counter/buffer state of the
// previous cycle.
module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 100000,
    parameter int DEAD       = 16,
    parameter int BRIGHT_W   = 4
) (
    input logic              mclk,
    input logic              reset,
    seg_scan_display_if.slave bus
);
    localparam int P_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int D_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Scan counters
    logic [P_W-1:0]      p_reg;
    logic [D_W-1:0]      d_reg;
    logic [BRIGHT_W-1:0] w_reg;

    // Double buffer
    logic [4*NUM_DIGITS-1:0] act_value_reg, pend_value_reg;
    logic [NUM_DIGITS-1:0]   act_dp_reg, pend_dp_reg;
    logic [NUM_DIGITS-1:0]   act_blank_reg, pend_blank_reg;
    logic                    upd_pending_reg;

    // Marks that the last edge was a frame boundary, so the tick lines up with
    // the first output cycle of digit 0.
    logic new_frame_reg;

    // Output registers
    logic [6:0]            seg_reg;
    logic                  dp_n_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic                  frame_tick_reg;

    logic slot_end;
    logic frame_end;
    assign slot_end  = (p_reg == P_W'(DIV - 1));
    assign frame_end = slot_end && (d_reg == D_W'(NUM_DIGITS - 1));

    // Per-digit view of the active word
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nib_zero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi]      = act_value_reg[4*gi +: 4];
            assign nib_zero[gi] = (act_value_reg[4*gi +: 4] == 4'h0);
        end
    endgenerate

    // Digit i>0 is suppressed when it and every digit to its left is zero.
    logic [NUM_DIGITS-1:0] suppress;
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & nib_zero[i];
            suppress[i] = zero_run & bus.lz_suppress;
        end
    end

    logic [3:0]            cur_nib;
    logic [6:0]            glyph;
    logic                  an_on;
    logic [6:0]            seg_next;
    logic                  dp_n_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        cur_nib = nib[d_reg];
        case (cur_nib)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
        seg_next  = (act_blank_reg[d_reg] || suppress[d_reg]) ? 7'h7F : glyph;
        // dp follows blanking but ignores leading-zero suppression
        dp_n_next = ~(act_dp_reg[d_reg] & ~act_blank_reg[d_reg]);
        // All-ones brightness is full duty; otherwise the PWM counter gates it.
        an_on     = (p_reg >= P_W'(DEAD)) &&
                    ((&bus.brightness) || (w_reg < bus.brightness));
        an_next   = an_on ? ~(NUM_DIGITS'(1) << d_reg) : '1;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            p_reg           <= '0;
            d_reg           <= '0;
            w_reg           <= '0;
            act_value_reg   <= '0;
            act_dp_reg      <= '0;
            act_blank_reg   <= '0;
            pend_value_reg  <= '0;
            pend_dp_reg     <= '0;
            pend_blank_reg  <= '0;
            upd_pending_reg <= 1'b0;
            new_frame_reg   <= 1'b0;
            seg_reg         <= 7'h7F;
            dp_n_reg        <= 1'b1;
            an_reg          <= '1;
            frame_tick_reg  <= 1'b0;
        end else begin
            w_reg <= w_reg + 1'b1;
            if (slot_end) begin
                p_reg <= '0;
                d_reg <= (d_reg == D_W'(NUM_DIGITS - 1)) ? '0 : d_reg + 1'b1;
            end else begin
                p_reg <= p_reg + 1'b1;
            end
            new_frame_reg <= frame_end;

            if (bus.load) begin
                pend_value_reg <= bus.value;
                pend_dp_reg    <= bus.dp;
                pend_blank_reg <= bus.blank;
            end

            // A load on the boundary edge bypasses pending straight to active.
            if (frame_end && bus.load) begin
                act_value_reg   <= bus.value;
                act_dp_reg      <= bus.dp;
                act_blank_reg   <= bus.blank;
                upd_pending_reg <= 1'b0;
            end else if (frame_end && upd_pending_reg) begin
                act_value_reg   <= pend_value_reg;
                act_dp_reg      <= pend_dp_reg;
                act_blank_reg   <= pend_blank_reg;
                upd_pending_reg <= 1'b0;
            end else if (bus.load) begin
                upd_pending_reg <= 1'b1;
            end

            seg_reg        <= seg_next;
            dp_n_reg       <= dp_n_next;
            an_reg         <= an_next;
            frame_tick_reg <= new_frame_reg;
        end
    end

    assign bus.seg         = seg_reg;
    assign bus.dp_n        = dp_n_reg;
    assign bus.an          = an_reg;
    assign bus.frame_tick  = frame_tick_reg;
    assign bus.upd_pending = upd_pending_reg;
endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
    localparam int N    = 4;
    localparam int DIV  = 8;
    localparam int DEAD = 2;
    localparam int BW   = 2;
    localparam int FRAME = N * DIV;

    logic mclk = 1'b0;
    logic reset = 1'b1;
    always #5 mclk = ~mclk;

    seg_scan_display_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus_if ();

    seg_scan_display #(
        .NUM_DIGITS(N), .DIV(DIV), .DEAD(DEAD), .BRIGHT_W(BW)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus_if)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: time since reset release plus the two buffers.
    int          t;
    logic [15:0] act_v, pend_v;
    logic [3:0]  act_dp, act_bl, pend_dp, pend_bl;
    logic        pend_f;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // One clock: predict outputs from the model, advance the model, clock the
    // DUT, compare one cycle after the edge.
    task automatic tick();
        int p, d, w;
        logic bnd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [3:0] nib;
        logic e_dp, e_ft, e_up;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0; e_up = 1'b0;
            t = 0; act_v = '0; pend_v = '0; act_dp = '0; act_bl = '0;
            pend_dp = '0; pend_bl = '0; pend_f = 1'b0;
        end else begin
            p = t % DIV;
            d = (t / DIV) % N;
            w = t % (1 << BW);
            bnd = (t % FRAME) == FRAME - 1;
            e_an = 4'hF;
            if (p >= DEAD && (bus_if.brightness == 2'd3 || w < int'(bus_if.brightness)))
                e_an[d] = 1'b0;
            nib = act_v[4*d +: 4];
            if (act_bl[d] || (bus_if.lz_suppress && d > 0 && (act_v >> (4*d)) == 16'd0))
                e_seg = 7'h7F;
            else
                e_seg = hex7(nib);
            e_dp = ~(act_dp[d] & ~act_bl[d]);
            e_ft = (t >= FRAME) && (t % FRAME == 0);
            if (bnd && bus_if.load) begin
                act_v = bus_if.value; act_dp = bus_if.dp; act_bl = bus_if.blank;
                pend_f = 1'b0;
            end else if (bnd && pend_f) begin
                act_v = pend_v; act_dp = pend_dp; act_bl = pend_bl;
                pend_f = 1'b0;
            end else if (bus_if.load) begin
                pend_f = 1'b1;
            end
            if (bus_if.load) begin
                pend_v = bus_if.value; pend_dp = bus_if.dp; pend_bl = bus_if.blank;
            end
            e_up = pend_f;
            t++;
        end
        @(posedge mclk);
        #1;
        compared++;
        assert (bus_if.an === e_an) else begin
            mismatched++;
            $error("FAIL an t=%0d got=%b exp=%b", t, bus_if.an, e_an);
        end
        compared++;
        assert (bus_if.seg === e_seg) else begin
            mismatched++;
            $error("FAIL seg t=%0d got=%b exp=%b", t, bus_if.seg, e_seg);
        end
        compared++;
        assert (bus_if.dp_n === e_dp) else begin
            mismatched++;
            $error("FAIL dp_n t=%0d got=%b exp=%b", t, bus_if.dp_n, e_dp);
        end
        compared++;
        assert (bus_if.frame_tick === e_ft) else begin
            mismatched++;
            $error("FAIL frame_tick t=%0d got=%b exp=%b", t, bus_if.frame_tick, e_ft);
        end
        compared++;
        assert (bus_if.upd_pending === e_up) else begin
            mismatched++;
            $error("FAIL upd_pending t=%0d got=%b exp=%b", t, bus_if.upd_pending, e_up);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv);
        bus_if.value = v; bus_if.dp = dpv; bus_if.blank = blv; bus_if.load = 1'b1;
        tick();
        bus_if.load = 1'b0;
        $display("load value=%h dp=%b blank=%b at t=%0d", v, dpv, blv, t);
    endtask

    initial begin
        bus_if.value = '0; bus_if.dp = '0; bus_if.blank = '0; bus_if.load = 1'b0;
        bus_if.lz_suppress = 1'b0; bus_if.brightness = 2'd3;

        // Reset state
        reset = 1'b1;
        run(2);
        reset = 1'b0;

        // Basic scan of 1234 at full brightness
        do_load(16'h1234, 4'b0000, 4'b0000);
        run(2 * FRAME + 5);

        // Leading-zero suppression on and off
        bus_if.lz_suppress = 1'b1;
        do_load(16'h00A0, 4'b0000, 4'b0000);
        run(2 * FRAME);
        bus_if.lz_suppress = 1'b0;
        run(FRAME);

        // Brightness levels
        bus_if.brightness = 2'd1;
        run(FRAME);
        bus_if.brightness = 2'd0;
        run(FRAME);
        bus_if.brightness = 2'd2;
        run(FRAME);
        bus_if.brightness = 2'd3;

        // Decimal points and blanking
        do_load(16'h8888, 4'b0101, 4'b0100);
        run(2 * FRAME);

        // Last load before the boundary wins
        run(5);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        run(3);
        do_load(16'h5555, 4'b0000, 4'b0000);
        run(FRAME + 4);

        // Load exactly on the boundary edge
        while (t % FRAME != FRAME - 1) tick();
        do_load(16'h9C7E, 4'b1000, 4'b0000);
        run(FRAME);

        // Reset mid-slot with a pending load
        run(11);
        do_load(16'hBEEF, 4'b1111, 4'b0000);
        run(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(2 * FRAME);

        // Randomized loads and live controls
        for (int k = 0; k < 30; k++) begin
            bus_if.lz_suppress = 1'($urandom_range(0, 1));
            bus_if.brightness  = 2'($urandom_range(0, 3));
            do_load(16'($urandom), 4'($urandom), 4'($urandom));
            run($urandom_range(1, 2 * FRAME));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display driver: scans NUM_DIGITS common-anode digits from a double-buffered hex word, with per-digit decimal point and blanking, leading-zero suppression, anti-ghosting dead time and PWM brightness control. It sits between the datapath that produces display values and the board's seg/dp/an pins. It is the generalised successor of the fixed 4-digit display path.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1..8).
- DIV, 100000: clock cycles per digit slot (100 MHz → 1 kHz per digit); must be ≥ DEAD+2.
- DEAD, 16: cycles at the start of each slot with all anodes off.
- BRIGHT_W, 4: brightness control width.

Ports:
- mclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point enable per digit (1 = lit).
- blank  in  NUM_DIGITS  force digit dark (1 = blank).
- load  in  1  one-cycle strobe; captures value/dp/blank into the pending buffer.
- lz_suppress  in  1  enable leading-zero suppression (sampled live).
- brightness  in  BRIGHT_W  duty level (sampled live).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode enables, active-low, at most one low.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- upd_pending  out  1  pending buffer holds data not yet applied.

## Operation
- Counters: prescaler p (0..DIV-1), digit index d (0..NUM_DIGITS-1), free-running PWM counter w (BRIGHT_W bits, +1 every cycle, wraps).
- p increments every cycle; at p==DIV-1, p→0 and d→d+1, with d wrapping NUM_DIGITS-1→0 (frame boundary).
- Buffers: load copies inputs to pending and sets upd_pending. At a frame boundary, if upd_pending is set, pending→active and upd_pending clears on the same edge.
- Load coinciding with a frame boundary: the new inputs go straight to active (bypass), and upd_pending ends 0.
- A later load before the boundary overwrites pending; the last load wins.
- Anode on condition: p ≥ DEAD AND (brightness == all-ones OR w < brightness). brightness 0 → dark.
- If the anode is on, an = ~(1<<d); otherwise an = all ones.
- Leading-zero suppression: digit i>0 is suppressed when lz_suppress=1 and active nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
- seg:
  - all ones when active blank[d]=1 or digit d is suppressed;
  - otherwise the hex decode of nibble d: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
- dp_n = ~(active dp[d] & ~active blank[d]). Suppression does not affect dp.
- seg and dp_n are driven for the current digit even while an is off (dead time).

## Timing
- All outputs are registered and reflect the counter/buffer state one cycle earlier.
- Reset, checked on the first clock after reset asserts:
  - outputs: an all ones, seg 7'h7F, dp_n 1, frame_tick 0, upd_pending 0;
  - state: p=0, d=0, w=0, active and pending buffers cleared.
- Reset mid-operation: same values on the next edge; a pending load is discarded.
- First anode low: cycle DEAD+1 after reset release, on digit 0 (with brightness all-ones).
- frame_tick is high in the cycle where the outputs first show d=0 of a new frame. The applied buffer takes effect in that same cycle.
- Load-to-display latency is at most NUM_DIGITS*DIV+1 cycles.
- Inputs other than load are ignored except at the load edge; lz_suppress and brightness are the exceptions and act live.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV=8, DEAD=2, BRIGHT_W=2.
- Reset, brightness=3, load value=16'h1234 → after the first frame boundary, digits 0..3 show 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001). an sequence 1110, 1101, 1011, 0111, each low for 6 of 8 cycles. frame_tick period is 32 cycles.
- value=16'h00A0, lz_suppress=1 → digits 3 and 2 seg=7F with an still cycling; digit 1=0001000, digit 0=1000000. With lz_suppress=0, digits 3 and 2 show 1000000.
- brightness=1 → during each slot, anode low only where w==0 and p≥2. brightness=0 → an stays 1111 all frame.
- dp=4'b0101, blank=4'b0100 → dp_n=0 on digits 0 only (digit 2 blanked, seg=7F, dp_n=1).
- Load 16'hFFFF mid-frame, then 16'h5555 before the boundary → upd_pending=1 until the boundary; only 5 is ever displayed. Load asserted exactly on the boundary edge → applied immediately, upd_pending stays 0.
- Assert reset mid-slot with a pending load → next cycle an=1111, seg=7F, upd_pending=0. After release, the display shows 0 on all digits.
